// File: rtl/pll_reconfig_ctrl_if.sv
// Request handshake between the system controller and the PLL sequencer.
interface pll_reconfig_ctrl_if;
  logic       req_valid;
  logic [5:0] req_idsel;
  logic       req_ready;

  modport master (output req_valid, output req_idsel, input  req_ready);
  modport slave  (input  req_valid, input  req_idsel, output req_ready);
endinterface

// File: rtl/pll_reconfig_ctrl.sv
// Gowin rPLL reset/IDSEL sequencer: hold reset, filter lock, settle, run.
// Handles loss of lock, bounded retries and sticky status flags.
module pll_reconfig_ctrl #(
  parameter logic [5:0]  DEFAULT_IDSEL = 6'd63,
  parameter int unsigned RESET_CYCLES  = 16,
  parameter int unsigned LOCK_FILTER   = 8,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter int unsigned MAX_RETRY     = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  pll_reconfig_ctrl_if.slave        req,
  input  logic                      clr_status,
  input  logic                      pll_lock,
  output logic                      pll_reset,
  output logic [5:0]                pll_idsel,
  output logic                      clk_ok,
  output logic                      busy,
  output logic                      fault,
  output logic                      err_timeout,
  output logic                      lock_lost,
  output logic [2:0]                state_o
);

  localparam int unsigned HW = $clog2(RESET_CYCLES + 1);
  localparam int unsigned FW = $clog2(LOCK_FILTER + 1);
  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    S_HOLD      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_SETTLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [5:0]    idsel_q, idsel_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic [SW-1:0] settle_cnt_q, settle_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          err_timeout_q, err_timeout_d;
  logic          lock_lost_q, lock_lost_d;
  logic          pll_reset_q, clk_ok_q, busy_q, fault_q, req_ready_q;
  logic          sync1_q, lock_s_q;

  logic          accept;
  logic          fail;
  logic          set_to;
  logic          set_ll;

  // Two-flop synchronizer for the asynchronous PLL lock pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= pll_lock;
      lock_s_q <= sync1_q;
    end
  end

  // Next-state, counter and sticky-flag logic.
  always_comb begin
    state_d      = state_q;
    idsel_d      = idsel_q;
    retry_d      = retry_q;
    hold_cnt_d   = '0;
    filt_cnt_d   = '0;
    settle_cnt_d = '0;
    to_cnt_d     = '0;
    fail         = 1'b0;
    set_to       = 1'b0;
    set_ll       = 1'b0;
    accept       = req.req_valid && req_ready_q;

    case (state_q)
      S_HOLD: begin
        if (hold_cnt_q == HW'(RESET_CYCLES - 1)) state_d = S_WAIT_LOCK;
        else                                     hold_cnt_d = hold_cnt_q + HW'(1);
      end
      S_WAIT_LOCK: begin
        filt_cnt_d = lock_s_q ? filt_cnt_q + FW'(1) : '0;
        // Filtered lock wins over a timeout expiring in the same cycle.
        if (lock_s_q && filt_cnt_q == FW'(LOCK_FILTER - 1)) begin
          state_d = S_SETTLE;
        end else if (to_cnt_q == TW'(LOCK_TIMEOUT - 1)) begin
          fail   = 1'b1;
          set_to = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      S_SETTLE: begin
        if (!lock_s_q) begin
          fail = 1'b1;
        end else if (settle_cnt_q == SW'(SETTLE_CYCLES - 1)) begin
          state_d = S_RUN;
          retry_d = '0;
        end else begin
          settle_cnt_d = settle_cnt_q + SW'(1);
        end
      end
      S_RUN: begin
        if (accept) begin
          state_d = S_HOLD;
          idsel_d = req.req_idsel;
          retry_d = '0;
        end else if (!lock_s_q) begin
          state_d = S_HOLD;
          set_ll  = 1'b1;
        end
      end
      S_FAULT: begin
        if (accept) begin
          state_d = S_HOLD;
          idsel_d = req.req_idsel;
          retry_d = '0;
        end
      end
      default: state_d = S_HOLD;
    endcase

    if (fail) begin
      if (retry_q < RW'(MAX_RETRY)) begin
        retry_d = retry_q + RW'(1);
        state_d = S_HOLD;
      end else begin
        state_d = S_FAULT;
      end
    end

    // Every state change starts its counters from zero; no state re-enters itself.
    if (state_d != state_q) begin
      hold_cnt_d   = '0;
      filt_cnt_d   = '0;
      settle_cnt_d = '0;
      to_cnt_d     = '0;
    end

    err_timeout_d = set_to | (err_timeout_q & ~clr_status);
    lock_lost_d   = set_ll | (lock_lost_q & ~clr_status);
  end

  // State, counters, and outputs registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_HOLD;
      idsel_q       <= DEFAULT_IDSEL;
      retry_q       <= '0;
      hold_cnt_q    <= '0;
      filt_cnt_q    <= '0;
      settle_cnt_q  <= '0;
      to_cnt_q      <= '0;
      err_timeout_q <= 1'b0;
      lock_lost_q   <= 1'b0;
      pll_reset_q   <= 1'b1;
      clk_ok_q      <= 1'b0;
      busy_q        <= 1'b1;
      fault_q       <= 1'b0;
      req_ready_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      idsel_q       <= idsel_d;
      retry_q       <= retry_d;
      hold_cnt_q    <= hold_cnt_d;
      filt_cnt_q    <= filt_cnt_d;
      settle_cnt_q  <= settle_cnt_d;
      to_cnt_q      <= to_cnt_d;
      err_timeout_q <= err_timeout_d;
      lock_lost_q   <= lock_lost_d;
      pll_reset_q   <= (state_d == S_HOLD) || (state_d == S_FAULT);
      clk_ok_q      <= (state_d == S_RUN);
      busy_q        <= (state_d != S_RUN) && (state_d != S_FAULT);
      fault_q       <= (state_d == S_FAULT);
      req_ready_q   <= (state_d == S_RUN) || (state_d == S_FAULT);
    end
  end

  assign req.req_ready = req_ready_q;
  assign pll_reset     = pll_reset_q;
  assign pll_idsel     = idsel_q;
  assign clk_ok        = clk_ok_q;
  assign busy          = busy_q;
  assign fault         = fault_q;
  assign err_timeout   = err_timeout_q;
  assign lock_lost     = lock_lost_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Bench for pll_reconfig_ctrl: behavioural PLL model plus timing expectations
// derived from the sequencing rules (hold length, lock latency, timeouts).
module tb_pll_reconfig_ctrl;

  localparam int RC  = 4;
  localparam int LF  = 8;
  localparam int SC  = 16;
  localparam int LT  = 100;
  localparam int MR  = 2;
  localparam int LAT_OK     = 2 + LF + SC;         // lock rise -> clk_ok
  localparam int LAT_SETTLE = 2 + LF;              // lock rise -> SETTLE
  localparam int FAULT_LAT  = (MR + 1) * (RC + LT); // accept -> FAULT with no lock

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr_status;
  logic       pll_lock;
  logic       pll_reset;
  logic [5:0] pll_idsel;
  logic       clk_ok, busy, fault, err_timeout, lock_lost;
  logic [2:0] state_o;

  pll_reconfig_ctrl_if req_if ();

  pll_reconfig_ctrl #(
    .DEFAULT_IDSEL(6'd63),
    .RESET_CYCLES (RC),
    .LOCK_FILTER  (LF),
    .SETTLE_CYCLES(SC),
    .LOCK_TIMEOUT (LT),
    .MAX_RETRY    (MR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req_if),
    .clr_status (clr_status),
    .pll_lock   (pll_lock),
    .pll_reset  (pll_reset),
    .pll_idsel  (pll_idsel),
    .clk_ok     (clk_ok),
    .busy       (busy),
    .fault      (fault),
    .err_timeout(err_timeout),
    .lock_lost  (lock_lost),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         lock_rise_cyc = -1;
  int         hold_run = 0;
  int         last_hold = 0;
  int         since = 0;
  int         lock_delay = 20;
  bit         pll_auto = 1'b1;
  logic [5:0] cur_idsel = 6'd63;

  task automatic drive_lock(input logic v);
    if (v && !pll_lock) lock_rise_cyc = cyc;
    pll_lock = v;
  endtask

  // One clock: sample point is 1 ns after the rising edge. The PLL model
  // raises lock lock_delay cycles after RESET is seen low.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (pll_reset === 1'b1) hold_run++;
    else if (hold_run != 0) begin last_hold = hold_run; hold_run = 0; end
    if (pll_auto) begin
      if (pll_reset === 1'b1) begin since = 0; drive_lock(1'b0); end
      else begin
        if (since >= lock_delay) drive_lock(1'b1);
        since++;
      end
    end
  endtask

  task automatic wait_clk_ok(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (clk_ok === 1'b1) begin at = cyc; break; end
    end
  endtask

  task automatic do_request(input logic [5:0] id);
    req_if.req_valid = 1'b1;
    req_if.req_idsel = id;
    step();
    req_if.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) step();
    checks++; if (state_o !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_o); end
    checks++; if (pll_reset !== 1'b1) begin failures++; $display("FAIL reset_pll_reset got=%0b exp=1", pll_reset); end
    checks++; if (pll_idsel !== 6'd63) begin failures++; $display("FAIL reset_idsel got=%0d exp=63", pll_idsel); end
    checks++; if ({clk_ok, req_if.req_ready, busy, fault, err_timeout, lock_lost} !== 6'b001000) begin
      failures++; $display("FAIL reset_flags got=%b exp=001000", {clk_ok, req_if.req_ready, busy, fault, err_timeout, lock_lost}); end
  endtask

  task automatic test_power_up();
    int at;
    lock_delay = 20;
    rst_n = 1'b1;
    hold_run = 1;
    wait_clk_ok(300, at);
    checks++; if (at !== lock_rise_cyc + LAT_OK) begin failures++; $display("FAIL powerup_latency got=%0d exp=%0d", at, lock_rise_cyc + LAT_OK); end
    checks++; if (last_hold !== RC) begin failures++; $display("FAIL powerup_hold got=%0d exp=%0d", last_hold, RC); end
    checks++; if (pll_idsel !== 6'd63) begin failures++; $display("FAIL powerup_idsel got=%0d exp=63", pll_idsel); end
    checks++; if ({req_if.req_ready, busy} !== 2'b10) begin failures++; $display("FAIL powerup_ready_busy got=%b exp=10", {req_if.req_ready, busy}); end
  endtask

  task automatic test_reconfigure(input logic [5:0] id);
    int at;
    lock_delay = $urandom_range(0, 60);
    checks++; if (req_if.req_ready !== 1'b1) begin failures++; $display("FAIL reconf_ready got=%0b exp=1", req_if.req_ready); end
    do_request(id);
    cur_idsel = id;
    checks++; if ({clk_ok, pll_reset, state_o} !== {1'b0, 1'b1, 3'd0}) begin
      failures++; $display("FAIL reconf_accept got=%b exp=01000", {clk_ok, pll_reset, state_o}); end
    checks++; if (pll_idsel !== id) begin failures++; $display("FAIL reconf_idsel got=%0d exp=%0d", pll_idsel, id); end
    wait_clk_ok(300, at);
    checks++; if (at !== lock_rise_cyc + LAT_OK) begin failures++; $display("FAIL reconf_latency got=%0d exp=%0d", at, lock_rise_cyc + LAT_OK); end
    checks++; if (last_hold !== RC) begin failures++; $display("FAIL reconf_hold got=%0d exp=%0d", last_hold, RC); end
    checks++; if (lock_lost !== 1'b0) begin failures++; $display("FAIL reconf_lock_lost got=%0b exp=0", lock_lost); end
  endtask

  // Drop lock for 5 cycles in RUN; optionally pulse clr_status on the set edge.
  task automatic test_lock_loss(input bit with_clr);
    int at;
    pll_auto = 1'b0;
    drive_lock(1'b0);
    step();
    step();
    checks++; if (clk_ok !== 1'b1) begin failures++; $display("FAIL loss_early got=%0b exp=1", clk_ok); end
    if (with_clr) clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    checks++; if ({clk_ok, state_o} !== {1'b0, 3'd0}) begin failures++; $display("FAIL loss_drop got=%b exp=0000", {clk_ok, state_o}); end
    checks++; if (lock_lost !== 1'b1) begin failures++; $display("FAIL loss_flag got=%0b exp=1", lock_lost); end
    checks++; if (pll_idsel !== cur_idsel) begin failures++; $display("FAIL loss_idsel got=%0d exp=%0d", pll_idsel, cur_idsel); end
    step();
    step();
    lock_delay = $urandom_range(0, 60);
    pll_auto = 1'b1;
    wait_clk_ok(300, at);
    checks++; if (at !== lock_rise_cyc + LAT_OK) begin failures++; $display("FAIL loss_recover got=%0d exp=%0d", at, lock_rise_cyc + LAT_OK); end
  endtask

  task automatic test_clr_status();
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    checks++; if (lock_lost !== 1'b0) begin failures++; $display("FAIL clr_lock_lost got=%0b exp=0", lock_lost); end
  endtask

  // Lock drop and accept land on the same edge, then no lock ever: FAULT.
  task automatic test_timeout_fault();
    int acc, fault_at, at;
    logic [5:0] id;
    id = 6'($urandom_range(0, 63));
    pll_auto = 1'b0;
    drive_lock(1'b0);
    step();
    step();
    do_request(id);
    acc = cyc;
    cur_idsel = id;
    checks++; if ({state_o, lock_lost} !== {3'd0, 1'b0}) begin failures++; $display("FAIL coincide_accept got=%b exp=0000", {state_o, lock_lost}); end
    checks++; if (pll_idsel !== id) begin failures++; $display("FAIL coincide_idsel got=%0d exp=%0d", pll_idsel, id); end
    fault_at = -1;
    for (int i = 0; i < 400; i++) begin
      step();
      if (cyc == acc + RC + LT - 1) begin
        checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL timeout_early got=%0b exp=0", err_timeout); end
      end
      if (cyc == acc + RC + LT) begin
        checks++; if (err_timeout !== 1'b1) begin failures++; $display("FAIL timeout_set got=%0b exp=1", err_timeout); end
      end
      if (fault === 1'b1) begin fault_at = cyc; break; end
    end
    checks++; if (fault_at !== acc + FAULT_LAT) begin failures++; $display("FAIL fault_time got=%0d exp=%0d", fault_at, acc + FAULT_LAT); end
    checks++; if ({pll_reset, busy, req_if.req_ready, clk_ok, state_o} !== {4'b1010, 3'd4}) begin
      failures++; $display("FAIL fault_outputs got=%b exp=1010100", {pll_reset, busy, req_if.req_ready, clk_ok, state_o}); end
    repeat (5) step();
    checks++; if (state_o !== 3'd4) begin failures++; $display("FAIL fault_stays got=%0d exp=4", state_o); end
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    checks++; if ({err_timeout, fault} !== 2'b01) begin failures++; $display("FAIL fault_clr got=%b exp=01", {err_timeout, fault}); end
    lock_delay = $urandom_range(0, 60);
    pll_auto = 1'b1;
    id = 6'($urandom_range(0, 63));
    do_request(id);
    cur_idsel = id;
    checks++; if ({state_o, fault, pll_idsel} !== {3'd0, 1'b0, id}) begin
      failures++; $display("FAIL fault_restart got=%b exp=%b", {state_o, fault, pll_idsel}, {3'd0, 1'b0, id}); end
    wait_clk_ok(300, at);
    checks++; if (at !== lock_rise_cyc + LAT_OK) begin failures++; $display("FAIL fault_recover got=%0d exp=%0d", at, lock_rise_cyc + LAT_OK); end
  endtask

  // Lock high for fewer than LF samples, one low sample, then steady high.
  task automatic test_glitch();
    int h, r, settle_at, at;
    logic [5:0] id;
    id = 6'($urandom_range(0, 63));
    h = $urandom_range(1, LF - 1);
    pll_auto = 1'b0;
    do_request(id);
    cur_idsel = id;
    drive_lock(1'b0);
    for (int i = 0; i < 20; i++) begin
      if (pll_reset === 1'b0) break;
      step();
    end
    drive_lock(1'b1);
    repeat (h) step();
    drive_lock(1'b0);
    step();
    drive_lock(1'b1);
    r = cyc;
    settle_at = -1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (state_o === 3'd2) begin settle_at = cyc; break; end
    end
    checks++; if (settle_at !== r + LAT_SETTLE) begin failures++; $display("FAIL glitch_settle got=%0d exp=%0d (h=%0d)", settle_at, r + LAT_SETTLE, h); end
    wait_clk_ok(100, at);
    checks++; if (at !== r + LAT_OK) begin failures++; $display("FAIL glitch_clk_ok got=%0d exp=%0d", at, r + LAT_OK); end
    since = 0;
    lock_delay = 0;
    pll_auto = 1'b1;
  endtask

  // A request held while busy is ignored until RUN, then accepted.
  task automatic test_busy_request();
    int at;
    logic [5:0] a, b;
    a = 6'($urandom_range(0, 31));
    b = 6'($urandom_range(32, 63));
    lock_delay = $urandom_range(0, 60);
    do_request(a);
    req_if.req_valid = 1'b1;
    req_if.req_idsel = b;
    at = -1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (clk_ok === 1'b1) begin at = cyc; break; end
      if (i < 3) begin
        checks++; if ({req_if.req_ready, pll_idsel} !== {1'b0, a}) begin
          failures++; $display("FAIL busy_ignore got=%b exp=%b", {req_if.req_ready, pll_idsel}, {1'b0, a}); end
      end
    end
    checks++; if (at !== lock_rise_cyc + LAT_OK) begin failures++; $display("FAIL busy_latency got=%0d exp=%0d", at, lock_rise_cyc + LAT_OK); end
    checks++; if (pll_idsel !== a) begin failures++; $display("FAIL busy_idsel got=%0d exp=%0d", pll_idsel, a); end
    step();
    req_if.req_valid = 1'b0;
    cur_idsel = b;
    checks++; if ({state_o, pll_idsel} !== {3'd0, b}) begin failures++; $display("FAIL busy_accept got=%b exp=%b", {state_o, pll_idsel}, {3'd0, b}); end
    wait_clk_ok(300, at);
    checks++; if (at !== lock_rise_cyc + LAT_OK) begin failures++; $display("FAIL busy_relock got=%0d exp=%0d", at, lock_rise_cyc + LAT_OK); end
  endtask

  task automatic test_mid_reset();
    int seen, at;
    logic [5:0] id;
    id = 6'($urandom_range(0, 62));
    lock_delay = $urandom_range(0, 60);
    do_request(id);
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (state_o === 3'd2) begin seen = 1; break; end
    end
    checks++; if (seen !== 1) begin failures++; $display("FAIL midrst_reach_settle got=%0d exp=1", seen); end
    rst_n = 1'b0;
    #2;
    checks++; if ({state_o, pll_reset, pll_idsel} !== {3'd0, 1'b1, 6'd63}) begin
      failures++; $display("FAIL midrst_state got=%b exp=%b", {state_o, pll_reset, pll_idsel}, {3'd0, 1'b1, 6'd63}); end
    checks++; if ({clk_ok, req_if.req_ready, busy, fault, err_timeout, lock_lost} !== 6'b001000) begin
      failures++; $display("FAIL midrst_flags got=%b exp=001000", {clk_ok, req_if.req_ready, busy, fault, err_timeout, lock_lost}); end
    step();
    step();
    rst_n = 1'b1;
    hold_run = 1;
    wait_clk_ok(300, at);
    checks++; if (at !== lock_rise_cyc + LAT_OK) begin failures++; $display("FAIL midrst_recover got=%0d exp=%0d", at, lock_rise_cyc + LAT_OK); end
    checks++; if ({last_hold, pll_idsel} !== {RC, 6'd63}) begin
      failures++; $display("FAIL midrst_hold_idsel got=%0d/%0d exp=%0d/63", last_hold, pll_idsel, RC); end
  endtask

  initial begin
    rst_n            = 1'b0;
    clr_status       = 1'b0;
    pll_lock         = 1'b0;
    req_if.req_valid = 1'b0;
    req_if.req_idsel = '0;
    test_reset();
    test_power_up();
    test_reconfigure(6'd60);
    for (int i = 0; i < 4; i++) test_reconfigure(6'($urandom_range(0, 63)));
    test_lock_loss(1'b0);
    test_clr_status();
    test_lock_loss(1'b1);
    test_clr_status();
    test_timeout_fault();
    test_glitch();
    test_busy_request();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench did not finish");
  end

endmodule

// File: doc/pll_reconfig_ctrl.md
# pll_reconfig_ctrl

Sequencing controller for the Gowin rPLL on the 27 MHz input clock domain. It owns the PLL `RESET` and dynamic `IDSEL` pins and applies a new input-divider setting on request. The reconfiguration sequence is: hold reset, wait for filtered lock, settle, then declare the output clock usable. It also detects loss of lock, retries failed lock attempts, and reports sticky status to the system controller.

## Interface
Parameters:
- `DEFAULT_IDSEL`, 6'd63: IDSEL driven out of reset. Raw pin value, no translation.
- `RESET_CYCLES`, 16: cycles `pll_reset` is held high per attempt. Must be ≥1.
- `LOCK_FILTER`, 8: consecutive synchronized-lock-high cycles required. Must be ≥1.
- `SETTLE_CYCLES`, 16: cycles from filtered lock to `clk_ok`. Must be ≥1.
- `LOCK_TIMEOUT`, 4096: maximum cycles allowed in WAIT_LOCK per attempt.
- `MAX_RETRY`, 2: extra attempts after the first failure before entering FAULT.

Ports:
- `clk` in 1: PLL input clock (27 MHz), free-running.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request to apply `req_idsel`.
- `req_idsel` in 6: requested IDSEL value.
- `req_ready` out 1: high in RUN and FAULT only.
- `clr_status` in 1: single-cycle pulse that clears the sticky flags.
- `pll_lock` in 1: PLL LOCK, asynchronous.
- `pll_reset` out 1: to PLL RESET.
- `pll_idsel` out 6: to PLL IDSEL.
- `clk_ok` out 1: PLL output clock is valid. High only in RUN.
- `busy` out 1: high when state is not RUN and not FAULT.
- `fault` out 1: high in FAULT.
- `err_timeout` out 1: sticky. Set on any WAIT_LOCK timeout.
- `lock_lost` out 1: sticky. Set when lock drops in RUN.
- `state_o` out 3: HOLD=0, WAIT_LOCK=1, SETTLE=2, RUN=3, FAULT=4.

## Operation
- `pll_lock` passes through a 2-flop synchronizer to form `lock_s`. All lock decisions use `lock_s`.
- **HOLD**
  - `pll_reset`=1.
  - Counts `RESET_CYCLES` cycles, then goes to WAIT_LOCK.
  - `pll_idsel` is updated only at HOLD entry and is stable for the entire hold.
- **WAIT_LOCK**
  - `pll_reset`=0.
  - The filter counter increments while `lock_s`=1 and clears when `lock_s`=0.
  - After `LOCK_FILTER` consecutive high samples, goes to SETTLE.
  - The timeout counter is not cleared by lock glitches. After `LOCK_TIMEOUT` cycles the attempt fails and `err_timeout` is set.
- **SETTLE**
  - Counts `SETTLE_CYCLES` cycles, then goes to RUN and clears the retry counter.
  - `lock_s`=0 during SETTLE counts as a failed attempt. `err_timeout` is not set.
- **Failed attempt**
  - If retries < `MAX_RETRY`: increment retries, go to HOLD with the same IDSEL.
  - Otherwise go to FAULT.
- **RUN**
  - `clk_ok`=1.
  - `lock_s`=0: go to HOLD with the same IDSEL and set `lock_lost`.
- **FAULT**
  - `pll_reset`=1. State holds until a request arrives.
- **Request accept**
  - A request is accepted when `req_valid`&&`req_ready`.
  - On accept: latch `req_idsel` into `pll_idsel`, clear retries, go to HOLD.
  - Request while `busy`: not accepted. The requester must hold `req_valid`.
- **Simultaneous events**
  - Accept and `lock_s` drop in the same RUN cycle: the accept wins and `lock_lost` is not set.
  - Flag set and `clr_status` in the same cycle: the set wins.
- Counter widths are `$clog2(param+1)`. No wrap-around is possible, because each counter is cleared on state entry.

## Timing
- **Reset values:** state=HOLD, `pll_reset`=1, `pll_idsel`=`DEFAULT_IDSEL`, `clk_ok`=0, `req_ready`=0, `busy`=1, `fault`=0, `err_timeout`=0, `lock_lost`=0, retries=0, synchronizer=0.
- **Mid-operation reset:** asserting `rst_n` low at any point returns the block immediately to the reset values, including during a reconfiguration.
- **Outputs:** all outputs are registered and derived from state.
- **Request accept:** accepted at edge N. After edge N the block shows state=HOLD, `clk_ok`=0, `pll_reset`=1 and the new `pll_idsel`.
- **HOLD duration:** `pll_reset` is high for exactly `RESET_CYCLES` cycles per attempt.
- **Lock-to-`clk_ok` latency:** `pll_lock` rises before edge E0; `clk_ok` rises after edge E(1+`LOCK_FILTER`+`SETTLE_CYCLES`). That is 2 synchronizer + `LOCK_FILTER` + `SETTLE_CYCLES` cycles.
- **Lock-loss latency:** `clk_ok` falls 3 cycles after `pll_lock` falls (2 synchronizer + 1).
- **Timeout:** the attempt fails on the `LOCK_TIMEOUT`-th cycle in WAIT_LOCK. HOLD is re-entered the next cycle.

## Test plan
Parameters for all scenarios: `RESET_CYCLES`=4, `LOCK_FILTER`=8, `SETTLE_CYCLES`=16, `LOCK_TIMEOUT`=100, `MAX_RETRY`=2.

1. **Power-up.** Release `rst_n`; the PLL model raises lock 20 cycles after `pll_reset` falls → `pll_reset` high for 4 cycles, `pll_idsel`=63, `clk_ok` rises 26 cycles after lock, `req_ready`=1.
2. **Reconfigure.** In RUN, pulse `req_valid` with `req_idsel`=6'd60 → the next cycle shows `clk_ok`=0, `pll_reset`=1, `pll_idsel`=60. Relock completes; `lock_lost`=0.
3. **Lock loss.** In RUN, drop `pll_lock` for 5 cycles → `clk_ok` is 0 within 3 cycles, `lock_lost`=1, HOLD with `pll_idsel` unchanged, then recovery to RUN.
4. **Timeout to FAULT.** Hold `pll_lock`=0 → 3 attempts of 4+100 cycles each, then FAULT with `err_timeout`=1, `fault`=1, `pll_reset`=1. A request then restarts the sequence.
5. **Glitch and status clear.**
   - Toggle lock high for 7 cycles, low for 1, then high → SETTLE is entered only after 8 consecutive high samples.
   - `clr_status` clears `lock_lost`/`err_timeout`.
   - `clr_status` coincident with a set event → the flag remains 1.
6. **Mid-sequence reset and ignored request.**
   - Assert `rst_n` low during SETTLE → all outputs return to their reset values asynchronously.
   - `req_valid` asserted while `busy` → not accepted, `pll_idsel` unchanged.
